trace_query_arbiter: RTL and testbench

Shares one signal-history query engine (a time-test or value-find tracker behind a start/data_valid handshake) between several filter-stage requesters. Each requester issues a look-back query. The arbiter grants requests in round-robin order, holds the engine's start level until a result or timeout, and returns the result to the granted requester. This lets the validity filter and later trace stages use one deep signal buffer instead of one buffer per consumer.

---
 rtl/trace_query_arbiter_pkg.sv | 14 +
 rtl/trace_query_arbiter_rr_picker.sv | 28 ++
 rtl/trace_query_arbiter.sv | 148 ++++++++++++++
 tb/tb_trace_query_arbiter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/trace_query_arbiter_pkg.sv
// Shared types and constants for the trace query arbiter and its consumers.
package trace_query_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        RESPOND = 2'd3
    } query_arb_state_e;

    // {end, start} = {-1, -1}: same marker the validity filter emits for "not found".
    localparam logic [63:0] QUERY_NOT_FOUND = {32'hFFFF_FFFF, 32'hFFFF_FFFF};

endpackage

// File: rtl/trace_query_arbiter_rr_picker.sv
// Rotating priority encoder: first set request at or after the round-robin pointer.
module query_rr_picker #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic               any_o,
    output logic [IDX_W-1:0]   grant_o
);

    logic [IDX_W-1:0] idx;

    // Walk from the farthest offset back to the pointer so the nearest hit wins.
    always_comb begin
        any_o   = 1'b0;
        grant_o = '0;
        idx     = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = IDX_W'((int'(ptr_i) + i) % NUM_REQ);
            if (req_i[idx]) begin
                any_o   = 1'b1;
                grant_o = idx;
            end
        end
    end

endmodule

// File: rtl/trace_query_arbiter.sv
// Round-robin arbiter sharing one signal-history query engine between filter stages.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   IDLE    | pick next requester, latch its index and query
//   ISSUE   | raise engine start, pulse req_ready, ignore stale engine valid
//   WAIT    | hold start until engine valid or timeout count expires
//   RESPOND | drop start, pulse rsp_valid (and rsp_timeout), advance rr_ptr
module trace_query_arbiter #(
    parameter int NUM_REQ        = 3,
    parameter int QUERY_WIDTH    = 32,
    parameter int RESULT_WIDTH   = 64,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [NUM_REQ-1:0]                    req_valid_i,
    input  logic [NUM_REQ-1:0][QUERY_WIDTH-1:0]   req_query_i,
    output logic [NUM_REQ-1:0]                    req_ready_o,
    output logic [NUM_REQ-1:0]                    rsp_valid_o,
    output logic [RESULT_WIDTH-1:0]               rsp_result_o,
    output logic                                  rsp_timeout_o,
    output logic                                  eng_start_o,
    output logic [QUERY_WIDTH-1:0]                eng_query_o,
    input  logic                                  eng_data_valid_i,
    input  logic [RESULT_WIDTH-1:0]               eng_result_i,
    output logic                                  busy_o,
    output logic [$clog2(NUM_REQ)-1:0]            grant_id_o
);

    import trace_query_arbiter_pkg::*;

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    // Sign-extend so the all-ones marker fills any result width.
    localparam logic [RESULT_WIDTH-1:0] NOT_FOUND = RESULT_WIDTH'($signed(QUERY_NOT_FOUND));

    query_arb_state_e          state_q, state_d;
    logic [IDX_W-1:0]          rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]          grant_id_q, grant_id_d;
    logic [QUERY_WIDTH-1:0]    query_q, query_d;
    logic [RESULT_WIDTH-1:0]   result_q, result_d;
    logic                      timeout_q, timeout_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      pick_any;
    logic [IDX_W-1:0]          pick_id;
    logic [NUM_REQ-1:0]        grant_onehot;

    query_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req_i   (req_valid_i),
        .ptr_i   (rr_ptr_q),
        .any_o   (pick_any),
        .grant_o (pick_id)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            query_q    <= '0;
            result_q   <= '0;
            timeout_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_id_q <= grant_id_d;
            query_q    <= query_d;
            result_q   <= result_d;
            timeout_q  <= timeout_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_id_d = grant_id_q;
        query_d    = query_q;
        result_d   = result_q;
        timeout_d  = timeout_q;
        cnt_d      = cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_id_d = pick_id;
                    query_d    = req_query_i[pick_id];
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d     = '0;
                timeout_d = 1'b0;
                state_d   = WAIT;
            end
            WAIT: begin
                if (eng_data_valid_i) begin
                    result_d  = eng_result_i;
                    timeout_d = 1'b0;
                    state_d   = RESPOND;
                end else if (cnt_q == CNT_LAST) begin
                    result_d  = NOT_FOUND;
                    timeout_d = 1'b1;
                    state_d   = RESPOND;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESPOND: begin
                rr_ptr_d = (grant_id_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_id_q + IDX_W'(1);
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign grant_onehot = NUM_REQ'(1) << grant_id_q;

    always_comb begin
        req_ready_o   = '0;
        rsp_valid_o   = '0;
        rsp_timeout_o = 1'b0;
        eng_start_o   = 1'b0;
        case (state_q)
            ISSUE: begin
                eng_start_o = 1'b1;
                req_ready_o = grant_onehot;
            end
            WAIT: eng_start_o = 1'b1;
            RESPOND: begin
                rsp_valid_o   = grant_onehot;
                rsp_timeout_o = timeout_q;
            end
            default: ;
        endcase
    end

    assign busy_o       = (state_q != IDLE);
    assign eng_query_o  = query_q;
    assign rsp_result_o = result_q;
    assign grant_id_o   = grant_id_q;

endmodule

// File: tb/tb_trace_query_arbiter.sv
// Directed self-checking bench for trace_query_arbiter (3 requesters, 8-cycle timeout).
module tb_trace_query_arbiter;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [2:0]           req_valid_i;
    logic [2:0][31:0]     req_query_i;
    logic [2:0]           req_ready_o;
    logic [2:0]           rsp_valid_o;
    logic [63:0]          rsp_result_o;
    logic                 rsp_timeout_o;
    logic                 eng_start_o;
    logic [31:0]          eng_query_o;
    logic                 eng_data_valid_i;
    logic [63:0]          eng_result_i;
    logic                 busy_o;
    logic [1:0]           grant_id_o;

    int n_assert = 0;
    int n_fail   = 0;

    trace_query_arbiter #(
        .NUM_REQ        (3),
        .QUERY_WIDTH    (32),
        .RESULT_WIDTH   (64),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid_i      (req_valid_i),
        .req_query_i      (req_query_i),
        .req_ready_o      (req_ready_o),
        .rsp_valid_o      (rsp_valid_o),
        .rsp_result_o     (rsp_result_o),
        .rsp_timeout_o    (rsp_timeout_o),
        .eng_start_o      (eng_start_o),
        .eng_query_o      (eng_query_o),
        .eng_data_valid_i (eng_data_valid_i),
        .eng_result_i     (eng_result_i),
        .busy_o           (busy_o),
        .grant_id_o       (grant_id_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_reset(input string pfx);
        chk({pfx, ".req_ready"},   64'(req_ready_o),   64'd0);
        chk({pfx, ".rsp_valid"},   64'(rsp_valid_o),   64'd0);
        chk({pfx, ".rsp_result"},  rsp_result_o,       64'd0);
        chk({pfx, ".rsp_timeout"}, 64'(rsp_timeout_o), 64'd0);
        chk({pfx, ".eng_start"},   64'(eng_start_o),   64'd0);
        chk({pfx, ".eng_query"},   64'(eng_query_o),   64'd0);
        chk({pfx, ".busy"},        64'(busy_o),        64'd0);
        chk({pfx, ".grant_id"},    64'(grant_id_o),    64'd0);
        chk({pfx, ".rr_ptr"},      64'(dut.rr_ptr_q),  64'd0);
    endtask

    // Requester id is pending and the DUT is in IDLE; engine answers dly cycles into WAIT.
    task automatic serve(input string tag, input int id, input logic [31:0] q,
                         input logic [63:0] res, input int dly);
        logic [2:0] oh;
        oh = 3'b001 << id;
        tick();
        chk({tag, ".issue_ready"}, 64'(req_ready_o), 64'(oh));
        chk({tag, ".issue_grant"}, 64'(grant_id_o),  64'(id));
        chk({tag, ".issue_query"}, 64'(eng_query_o), 64'(q));
        chk({tag, ".issue_start"}, 64'(eng_start_o), 64'd1);
        req_query_i[id] = ~q;
        tick();
        req_valid_i[id] = 1'b0;
        chk({tag, ".wait_query_held"}, 64'(eng_query_o), 64'(q));
        chk({tag, ".wait_ready_low"},  64'(req_ready_o), 64'd0);
        repeat (dly) tick();
        eng_data_valid_i = 1'b1;
        eng_result_i     = res;
        tick();
        chk({tag, ".rsp_valid"},   64'(rsp_valid_o),   64'(oh));
        chk({tag, ".rsp_result"},  rsp_result_o,       res);
        chk({tag, ".rsp_timeout"}, 64'(rsp_timeout_o), 64'd0);
        chk({tag, ".rsp_start"},   64'(eng_start_o),   64'd0);
        eng_data_valid_i = 1'b0;
        tick();
        chk({tag, ".idle_busy"},   64'(busy_o),        64'd0);
        chk({tag, ".idle_rsp"},    64'(rsp_valid_o),   64'd0);
    endtask

    initial begin
        rst_n            = 1'b0;
        req_valid_i      = '0;
        req_query_i      = '0;
        eng_data_valid_i = 1'b0;
        eng_result_i     = '0;
        tick();
        tick();
        chk_reset("por");
        rst_n = 1'b1;
        tick();
        chk("por.idle_busy", 64'(busy_o), 64'd0);

        // Single request: engine valid three cycles after start rises.
        req_query_i[1] = 32'd5;
        req_valid_i    = 3'b010;
        serve("single", 1, 32'd5, {32'd20, 32'd10}, 2);
        chk("single.rr_ptr", 64'(dut.rr_ptr_q), 64'd2);

        // All three request together after requester 1 was served.
        req_query_i[0] = 32'd100;
        req_query_i[1] = 32'd101;
        req_query_i[2] = 32'd102;
        req_valid_i    = 3'b111;
        serve("rr_a", 2, 32'd102, {32'd2, 32'd1}, 0);
        serve("rr_b", 0, 32'd100, {32'd4, 32'd3}, 1);
        serve("rr_c", 1, 32'd101, {32'd6, 32'd5}, 0);
        chk("rr.rr_ptr", 64'(dut.rr_ptr_q), 64'd2);

        // Timeout: engine never answers.
        req_query_i[0] = 32'd7;
        req_valid_i    = 3'b001;
        tick();
        chk("tmo.issue_ready", 64'(req_ready_o), 64'b001);
        tick();
        req_valid_i = '0;
        repeat (7) tick();
        chk("tmo.wait8_rsp",   64'(rsp_valid_o), 64'd0);
        chk("tmo.wait8_start", 64'(eng_start_o), 64'd1);
        tick();
        chk("tmo.rsp_valid",   64'(rsp_valid_o),   64'b001);
        chk("tmo.rsp_result",  rsp_result_o,       64'hFFFF_FFFF_FFFF_FFFF);
        chk("tmo.rsp_timeout", 64'(rsp_timeout_o), 64'd1);
        chk("tmo.rsp_start",   64'(eng_start_o),   64'd0);
        tick();
        chk("tmo.idle_timeout", 64'(rsp_timeout_o), 64'd0);
        chk("tmo.rr_ptr",       64'(dut.rr_ptr_q),  64'd1);

        // Stale engine valid held through ISSUE must be ignored.
        req_query_i[1]   = 32'd9;
        req_valid_i      = 3'b010;
        eng_data_valid_i = 1'b1;
        eng_result_i     = {32'd99, 32'd99};
        tick();
        chk("stale.issue_ready", 64'(req_ready_o), 64'b010);
        tick();
        chk("stale.wait1_rsp",  64'(rsp_valid_o), 64'd0);
        chk("stale.wait1_busy", 64'(busy_o),      64'd1);
        req_valid_i      = '0;
        eng_data_valid_i = 1'b0;
        tick();
        tick();
        chk("stale.wait3_rsp", 64'(rsp_valid_o), 64'd0);
        eng_data_valid_i = 1'b1;
        eng_result_i     = {32'd7, 32'd3};
        tick();
        chk("stale.rsp_valid",  64'(rsp_valid_o), 64'b010);
        chk("stale.rsp_result", rsp_result_o,     {32'd7, 32'd3});
        eng_data_valid_i = 1'b0;
        tick();

        // Reset pulse during WAIT discards the in-flight response.
        req_query_i[0] = 32'd11;
        req_valid_i    = 3'b001;
        tick();
        chk("rst.issue_grant", 64'(grant_id_o), 64'd0);
        tick();
        req_valid_i = '0;
        tick();
        rst_n            = 1'b0;
        eng_data_valid_i = 1'b1;
        eng_result_i     = {32'd5, 32'd5};
        tick();
        chk_reset("rst");
        rst_n            = 1'b1;
        eng_data_valid_i = 1'b0;
        tick();
        chk("rst.after_rsp",  64'(rsp_valid_o), 64'd0);
        chk("rst.after_busy", 64'(busy_o),      64'd0);
        req_query_i[2] = 32'd42;
        req_valid_i    = 3'b100;
        serve("post_rst", 2, 32'd42, {32'd1, 32'd2}, 1);
        chk("post_rst.rr_ptr", 64'(dut.rr_ptr_q), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected test completion");
        $fatal(1);
    end

endmodule
